melody_sequencer: RTL and testbench



---
 rtl/melody_sequencer.sv | 153 +++++++++++++++
 tb/tb_melody_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// melody_sequencer: walks a song table in an external synchronous ROM and
// presents each note code to the buzzer for dur*BEAT_CYCLES cycles. A silent
// gap of GAP_CYCLES follows each note. Supports start, stop, pause and loop.
module melody_sequencer #(
    parameter int AW          = 6,
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          pause,
    input  logic          loop,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    output logic [3:0]    note,
    output logic          playing,
    output logic          done,
    output logic [AW-1:0] index
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP} state_t;

    localparam int CW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] BEAT_LAST = CW'(BEAT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};

    state_t        state;
    logic [CW-1:0] cyc;
    logic [3:0]    beat;
    logic [GW-1:0] gap;
    logic [3:0]    note_held;

    logic [3:0]    dur;
    logic [3:0]    note_field;
    logic          play_final;
    logic          gap_final;
    logic          advance;
    logic          end_song;
    logic          frozen;

    assign dur        = rom_data[3:0];
    assign note_field = rom_data[7:4];

    // Decode the timing events that move the walker to the next table entry.
    always_comb begin
        play_final = (state == PLAY) && !pause && (cyc == BEAT_LAST) && (beat == 4'd0);
        gap_final  = (state == GAP) && !pause && (gap == GAP_LAST);
        if (GAP_CYCLES == 0) begin
            advance = play_final;
        end else begin
            advance = gap_final;
        end
        // Running off the last address ends the song rather than wrapping
        // into whatever stale contents sit at address 0.
        end_song = ((state == LOAD) && (dur == 4'd0)) ||
                   (advance && (rom_addr == ADDR_LAST));
        frozen   = pause && ((state == PLAY) || (state == GAP));
    end

    // Pause silences the buzzer in the very cycle it freezes the counters,
    // so the audible note length stays exactly dur*BEAT_CYCLES.
    assign note = frozen ? 4'd0 : note_held;

    // Sequencer state machine, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            note_held <= 4'd0;
            playing   <= 1'b0;
            done      <= 1'b0;
            rom_addr  <= '0;
            index     <= '0;
            cyc       <= '0;
            beat      <= 4'd0;
            gap       <= '0;
        end else if (stop) begin
            state     <= IDLE;
            note_held <= 4'd0;
            playing   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (end_song) begin
                note_held <= 4'd0;
                if (loop) begin
                    rom_addr <= '0;
                    state    <= FETCH;
                end else begin
                    done    <= 1'b1;
                    playing <= 1'b0;
                    state   <= IDLE;
                end
            end else if (advance) begin
                note_held <= 4'd0;
                rom_addr  <= rom_addr + AW'(1);
                state     <= FETCH;
            end else begin
                case (state)
                    IDLE: begin
                        note_held <= 4'd0;
                        if (start) begin
                            rom_addr <= '0;
                            playing  <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                    FETCH: begin
                        state <= LOAD;
                    end
                    LOAD: begin
                        index     <= rom_addr;
                        // Codes 8..15 are not musical notes and play as rest.
                        note_held <= note_field[3] ? 4'd0 : note_field;
                        cyc       <= '0;
                        beat      <= dur - 4'd1;
                        state     <= PLAY;
                    end
                    PLAY: begin
                        if (!pause) begin
                            if (cyc == BEAT_LAST) begin
                                cyc <= '0;
                                if (beat == 4'd0) begin
                                    note_held <= 4'd0;
                                    gap       <= '0;
                                    state     <= GAP;
                                end else begin
                                    beat <= beat - 4'd1;
                                end
                            end else begin
                                cyc <= cyc + CW'(1);
                            end
                        end
                    end
                    GAP: begin
                        if (!pause) begin
                            gap <= gap + GW'(1);
                        end
                    end
                    default: begin
                        note_held <= 4'd0;
                        playing   <= 1'b0;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer (AW=3, BEAT_CYCLES=4, GAP_CYCLES=2).
// A behavioural model expands the song table into one expected
// {note, playing, done, index} word per cycle; the run loop pops and compares.
`timescale 1ns/1ps
module tb_melody_sequencer;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic          loop = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data = 8'h00;
    logic [3:0]    note;
    logic          playing;
    logic          done;
    logic [AW-1:0] index;

    logic [7:0] rom [0:7];

    int checks = 0;
    int errors = 0;

    int q[$];
    int t;
    int pause_lo, pause_hi;
    int cut_at, cut_rst, cut_idx;
    int idx_m;

    melody_sequencer #(.AW(AW), .BEAT_CYCLES(4), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .loop(loop), .rom_addr(rom_addr), .rom_data(rom_data), .note(note),
        .playing(playing), .done(done), .index(index)
    );

    always #5 clk = ~clk;

    // Synchronous song ROM model: data valid one cycle after the address.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One expected cycle; after a stop/rst cut every cycle is idle.
    task automatic push_raw(input int n, input int p, input int d);
        int i2;
        if (t == cut_at) cut_idx = idx_m;
        i2 = idx_m;
        if (cut_at >= 0 && t > cut_at) begin
            n = 0; p = 0; d = 0;
            i2 = (cut_rst != 0) ? 0 : cut_idx;
        end
        q.push_back((n << 5) | (p << 4) | (d << 3) | i2);
        t++;
    endtask

    // A PLAY/GAP cycle; paused cycles are silent and do not consume time.
    task automatic push_timed(input int n);
        while (t >= pause_lo && t < pause_hi) push_raw(0, 1, 0);
        push_raw(n, 1, 0);
    endtask

    task automatic push_fl();
        push_raw(0, 1, 0);
        push_raw(0, 1, 0);
    endtask

    // Expand the ROM contents into the expected cycle stream.
    task automatic gen_song(input int passes);
        int a, d, n, nv;
        bit fin;
        logic [7:0] w;
        t = 0; a = 0; fin = 1'b0;
        push_fl();
        while (!fin) begin
            w = rom[a];
            d = int'(w[3:0]);
            n = int'(w[7:4]);
            if (d != 0) begin
                idx_m = a;
                nv = (n >= 1 && n <= 7) ? n : 0;
                repeat (d * 4) push_timed(nv);
                repeat (2) push_timed(0);
            end
            if (d == 0 || a == 7) begin
                if (passes > 0) begin
                    passes--;
                    a = 0;
                    push_fl();
                end else begin
                    push_raw(0, 0, 1);
                    push_raw(0, 0, 0);
                    fin = 1'b1;
                end
            end else begin
                a++;
                push_fl();
            end
        end
    endtask

    // Optionally pulse start, then compare one queue entry per cycle.
    task automatic run(input string tag, input bit do_start, input int stop_at,
                       input int rst_at, input int loop_off_at);
        int c, got, e;
        if (do_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        c = 0;
        while (q.size() > 0) begin
            pause = (c >= pause_lo && c < pause_hi);
            stop  = (c == stop_at);
            rst   = (c == rst_at);
            if (c == loop_off_at) loop = 1'b0;
            @(negedge clk);
            e = q.pop_front();
            got = int'({note, playing, done, index});
            check_eq(tag, got, e);
            @(posedge clk); #1;
            c++;
        end
        pause = 1'b0; stop = 1'b0; rst = 1'b0;
    endtask

    task automatic clear_model();
        pause_lo = -1; pause_hi = -1; cut_at = -1; cut_rst = 0; cut_idx = 0;
        q.delete();
    endtask

    task automatic load_rom(input logic [63:0] img);
        for (int i = 0; i < 8; i++) rom[i] = img[63 - 8*i -: 8];
    endtask

    initial begin
        idx_m = 0;
        clear_model();
        load_rom(64'h12_31_00_00_00_00_00_00);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset_note", int'(note), 0);
        check_eq("reset_playing", int'(playing), 0);
        check_eq("reset_done", int'(done), 0);
        check_eq("reset_rom_addr", int'(rom_addr), 0);
        check_eq("reset_index", int'(index), 0);
        @(posedge clk); #1;

        // Basic two-note song with end marker.
        clear_model(); gen_song(0);
        run("basic", 1'b1, -1, -1, -1);

        // Loop once, loop cleared mid second pass, then done.
        clear_model(); loop = 1'b1; gen_song(1);
        run("loop", 1'b1, -1, -1, 30);

        // Pause for five cycles from PLAY cycle 3 of entry 0x22.
        clear_model(); load_rom(64'h22_00_00_00_00_00_00_00);
        pause_lo = 5; pause_hi = 10; gen_song(0);
        run("pause", 1'b1, -1, -1, -1);

        // Stop at PLAY cycle 2 of entry 0x51, then restart from address 0.
        clear_model(); load_rom(64'h51_00_00_00_00_00_00_00);
        cut_at = 4; gen_song(0); idx_m = cut_idx;
        run("stop", 1'b1, 4, -1, -1);
        clear_model(); gen_song(0);
        run("restart", 1'b1, -1, -1, -1);

        // Full table without marker, one rest code 9.
        clear_model(); load_rom(64'h11_21_93_31_41_51_61_71);
        gen_song(0);
        run("full_table", 1'b1, -1, -1, -1);
        check_eq("end_rom_addr", int'(rom_addr), 7);

        // Reset in the first gap cycle.
        clear_model(); load_rom(64'h12_31_00_00_00_00_00_00);
        cut_at = 10; cut_rst = 1; gen_song(0); idx_m = 0;
        run("rst_gap", 1'b1, -1, 10, -1);
        check_eq("rst_rom_addr", int'(rom_addr), 0);

        // start and stop together in IDLE: stays idle.
        clear_model();
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        t = 0;
        repeat (6) push_raw(0, 0, 0);
        run("start_stop", 1'b0, -1, -1, -1);
        check_eq("start_stop_rom_addr", int'(rom_addr), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
